// File: rtl/uart_pkg.sv
// uart_pkg: shared UART receive types and constants
package uart_pkg;
  typedef enum logic [2:0] {WAIT_IDLE, IDLE, START, DATA, STOP} rx_state_t;
  localparam int UART_DATA_BITS = 8;
endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: first-word fall-through FIFO, pop-before-push when full
module uart_rx_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic [W-1:0] din_i,
  output logic         full_o,
  input  logic         pop_i,
  output logic [W-1:0] dout_o,
  output logic         empty_o
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0] wr_q, rd_q;
  logic [W-1:0] mem_q [DEPTH];
  logic do_pop, do_push;
  assign empty_o = wr_q == rd_q;
  assign full_o = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_pop = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign dout_o = mem_q[rd_q[AW-1:0]];
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (do_push) mem_q[wr_q[AW-1:0]] <= din_i;
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop) rd_q <= rd_q + 1'b1;
    end
  end
endmodule

// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 serial receiver with mid-bit sampling and receive FIFO
module uart_receiver import uart_pkg::*; #(
  parameter int BIT_CYCLES = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rx_i,
  output logic [UART_DATA_BITS-1:0] data_o,
  output logic                      valid_o,
  input  logic                      ready_i,
  output logic                      frame_err_o,
  output logic                      overrun_o,
  input  logic                      err_clr_i
);
  localparam int CW = $clog2(BIT_CYCLES);
  localparam logic [CW-1:0] FULL_C = CW'(BIT_CYCLES - 1);
  localparam logic [CW-1:0] HALF_C = CW'(BIT_CYCLES / 2 - 1);
  rx_state_t state_q, state_d;
  logic [1:0] sync_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] bit_q, bit_d;
  logic [UART_DATA_BITS-1:0] sh_q, sh_d;
  logic frame_err_q, overrun_q, push, ferr, full, empty, rx_s, tick;
  assign rx_s = sync_q[1];
  assign tick = cnt_q == '0;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    bit_d = bit_q;
    sh_d = sh_q;
    push = 1'b0;
    ferr = 1'b0;
    case (state_q)
      WAIT_IDLE: state_d = rx_s ? IDLE : WAIT_IDLE;
      IDLE: if (!rx_s) begin
        state_d = START;
        cnt_d = HALF_C;
      end
      START: if (tick) begin
        state_d = rx_s ? IDLE : DATA;
        cnt_d = FULL_C;
        bit_d = '0;
      end else cnt_d = cnt_q - 1'b1;
      DATA: if (tick) begin
        sh_d = {rx_s, sh_q[UART_DATA_BITS-1:1]};
        bit_d = bit_q + 1'b1;
        cnt_d = FULL_C;
        state_d = (bit_q == 3'(UART_DATA_BITS - 1)) ? STOP : DATA;
      end else cnt_d = cnt_q - 1'b1;
      STOP: if (tick) begin
        push = rx_s;
        ferr = !rx_s;
        state_d = rx_s ? IDLE : WAIT_IDLE;
      end else cnt_d = cnt_q - 1'b1;
      default: state_d = WAIT_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= WAIT_IDLE;
      sync_q <= '0;
      cnt_q <= '0;
      bit_q <= '0;
      sh_q <= '0;
      frame_err_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q <= {sync_q[0], rx_i};
      cnt_q <= cnt_d;
      bit_q <= bit_d;
      sh_q <= sh_d;
      frame_err_q <= ferr;
      overrun_q <= (push && full && !ready_i) || (overrun_q && !err_clr_i);
    end
  end
  uart_rx_fifo #(.DEPTH(FIFO_DEPTH), .W(UART_DATA_BITS)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push_i(push),
    .din_i(sh_q),
    .full_o(full),
    .pop_i(ready_i),
    .dout_o(data_o),
    .empty_o(empty)
  );
  assign valid_o = !empty;
  assign frame_err_o = frame_err_q;
  assign overrun_o = overrun_q;
endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: directed frames against a byte scoreboard
module tb_uart_receiver;
  localparam int BC = 16;
  logic clk = 0, rst = 1, rx_i = 1, ready_i = 1, err_clr_i = 0;
  logic [7:0] data_o;
  logic valid_o, frame_err_o, overrun_o;
  int checks = 0, failures = 0, ferr_cnt = 0, f0;
  logic [7:0] q[$];
  always #5 clk = ~clk;
  uart_receiver #(.BIT_CYCLES(BC), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .rx_i(rx_i), .data_o(data_o), .valid_o(valid_o),
    .ready_i(ready_i), .frame_err_o(frame_err_o), .overrun_o(overrun_o), .err_clr_i(err_clr_i)
  );
  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic send_frame(input logic [7:0] b, input logic stop);
    rx_i = 0;
    repeat (BC) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_i = b[i];
      repeat (BC) @(negedge clk);
    end
    rx_i = stop;
    repeat (BC) @(negedge clk);
    rx_i = 1;
  endtask
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic drain(input string tag);
    for (int i = 0; i < 200 && q.size() != 0; i++) @(negedge clk);
    @(negedge clk);
    chk({tag, "_sb_empty"}, 8'(q.size()), 8'd0);
    chk({tag, "_valid_low"}, {7'd0, valid_o}, 8'd0);
  endtask
  always @(negedge clk) begin
    #1;
    if (frame_err_o === 1'b1) ferr_cnt++;
    if (valid_o === 1'b1 && ready_i === 1'b1) begin
      checks++;
      assert (q.size() != 0) else begin
        failures++;
        $error("FAIL unexpected_pop got=%0h exp=none", data_o);
      end
      if (q.size() != 0) chk("pop_data", data_o, q.pop_front());
    end
  end
  initial begin
    idle(3);
    rst = 0;
    chk("rst_data", data_o, 8'h00);
    chk("rst_valid", {7'd0, valid_o}, 8'd0);
    chk("rst_ferr", {7'd0, frame_err_o}, 8'd0);
    chk("rst_ovr", {7'd0, overrun_o}, 8'd0);
    idle(10);
    q.push_back(8'h55);
    send_frame(8'h55, 1);
    drain("t1");
    chk("t1_ferr", 8'(ferr_cnt), 8'd0);
    chk("t1_ovr", {7'd0, overrun_o}, 8'd0);
    rx_i = 0;
    idle(4);
    rx_i = 1;
    idle(30);
    chk("t2_glitch_valid", {7'd0, valid_o}, 8'd0);
    chk("t2_glitch_ferr", 8'(ferr_cnt), 8'd0);
    q.push_back(8'hC3);
    send_frame(8'hC3, 1);
    drain("t2");
    f0 = ferr_cnt;
    send_frame(8'hA3, 0);
    rx_i = 0;
    idle(40);
    rx_i = 1;
    idle(10);
    chk("t3_ferr_pulses", 8'(ferr_cnt - f0), 8'd1);
    chk("t3_valid", {7'd0, valid_o}, 8'd0);
    q.push_back(8'h3C);
    send_frame(8'h3C, 1);
    drain("t3");
    chk("t3_ferr_after", 8'(ferr_cnt - f0), 8'd1);
    ready_i = 0;
    for (int i = 1; i <= 5; i++) begin
      if (i < 5) q.push_back(8'(i));
      send_frame(8'(i), 1);
      if (i == 4) chk("t4_ovr_at_full", {7'd0, overrun_o}, 8'd0);
    end
    chk("t4_valid", {7'd0, valid_o}, 8'd1);
    chk("t4_head", data_o, 8'h01);
    chk("t4_ovr", {7'd0, overrun_o}, 8'd1);
    ready_i = 1;
    drain("t4");
    chk("t4_ovr_sticky", {7'd0, overrun_o}, 8'd1);
    err_clr_i = 1;
    @(negedge clk);
    err_clr_i = 0;
    chk("t4_ovr_clr", {7'd0, overrun_o}, 8'd0);
    f0 = ferr_cnt;
    rx_i = 0;
    idle(BC * 4 + BC / 2);
    rst = 1;
    idle(3);
    rst = 0;
    idle(60);
    chk("t5_valid", {7'd0, valid_o}, 8'd0);
    chk("t5_ferr", 8'(ferr_cnt - f0), 8'd0);
    rx_i = 1;
    idle(20);
    q.push_back(8'h7E);
    send_frame(8'h7E, 1);
    drain("t5");
    ready_i = 0;
    for (int i = 1; i <= 4; i++) begin
      q.push_back(8'(8'h11 * i));
      send_frame(8'(8'h11 * i), 1);
    end
    q.push_back(8'h99);
    fork
      send_frame(8'h99, 1);
      begin
        idle(154);
        ready_i = 1;
        @(negedge clk);
        ready_i = 0;
      end
    join
    idle(2);
    chk("t6_ovr", {7'd0, overrun_o}, 8'd0);
    chk("t6_valid", {7'd0, valid_o}, 8'd1);
    chk("t6_head", data_o, 8'h22);
    chk("t6_sb_left", 8'(q.size()), 8'd4);
    ready_i = 1;
    drain("t6");
    chk("t6_ferr", 8'(ferr_cnt - f0), 8'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
